// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, EX redirects,
// data-memory wait handshake with timeout, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W     = 5,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  idex_mem_ren_i,
    input  logic [REG_ADDR_W-1:0] idex_rd_addr_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs2_addr_i,
    input  logic                  ifid_rs1_used_i,
    input  logic                  ifid_rs2_used_i,
    input  logic                  ex_redirect_i,
    input  logic                  exmem_mem_req_i,
    input  logic                  dmem_ack_i,
    output logic                  dmem_req_o,
    output logic                  hold_pc_o,
    output logic                  hold_ifid_o,
    output logic                  hold_idex_o,
    output logic                  hold_exmem_o,
    output logic                  flush_ifid_o,
    output logic                  bubble_idex_o,
    output logic                  bubble_memwb_o,
    output logic                  mem_err_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    // state  | meaning
    // IDLE   | no memory access outstanding; request follows EX/MEM
    // WAIT   | request issued, waiting for ack, timeout counter running
    // ERR    | memory never answered; pipeline frozen until reset
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    localparam int WCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);
    localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]     state;
    logic [WCW-1:0] wait_cnt;
    logic           mem_busy;
    logic           load_use;
    logic           redirect_taken;
    logic           rs1_hit;
    logic           rs2_hit;

    // Request depends only on state and EX/MEM, never on the ack.
    always_comb begin
        dmem_req_o = 1'b0;
        if (!rst_i) begin
            case (state)
                S_IDLE:  dmem_req_o = exmem_mem_req_i;
                S_WAIT:  dmem_req_o = 1'b1;
                default: dmem_req_o = 1'b0;
            endcase
        end
    end

    assign mem_busy = dmem_req_o & ~dmem_ack_i;
    assign rs1_hit  = ifid_rs1_used_i & (ifid_rs1_addr_i == idex_rd_addr_i);
    assign rs2_hit  = ifid_rs2_used_i & (ifid_rs2_addr_i == idex_rd_addr_i);
    assign load_use = idex_mem_ren_i & (idex_rd_addr_i != '0) & (rs1_hit | rs2_hit);

    always_comb begin
        hold_pc_o      = 1'b0;
        hold_ifid_o    = 1'b0;
        hold_idex_o    = 1'b0;
        hold_exmem_o   = 1'b0;
        flush_ifid_o   = 1'b0;
        bubble_idex_o  = 1'b0;
        bubble_memwb_o = 1'b0;
        mem_err_o      = 1'b0;
        redirect_taken = 1'b0;
        if (rst_i) begin
            flush_ifid_o   = 1'b1;
            bubble_idex_o  = 1'b1;
            bubble_memwb_o = 1'b1;
        end else if (state == S_ERR || mem_busy) begin
            hold_pc_o      = 1'b1;
            hold_ifid_o    = 1'b1;
            hold_idex_o    = 1'b1;
            hold_exmem_o   = 1'b1;
            bubble_memwb_o = 1'b1;
            mem_err_o      = (state == S_ERR);
        end else if (ex_redirect_i) begin
            // Wrong-path ID instruction is discarded, so any load-use on it is moot.
            flush_ifid_o   = 1'b1;
            bubble_idex_o  = 1'b1;
            redirect_taken = 1'b1;
        end else if (load_use) begin
            hold_pc_o      = 1'b1;
            hold_ifid_o    = 1'b1;
            bubble_idex_o  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_busy) begin
                        state    <= S_WAIT;
                        wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack_i) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                default: state <= S_ERR;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (hold_pc_o && stall_cnt_o != CNT_MAX) begin
                stall_cnt_o <= stall_cnt_o + CNT_ONE;
            end
            if (redirect_taken && flush_cnt_o != CNT_MAX) begin
                flush_cnt_o <= flush_cnt_o + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared cycle by cycle with a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int RW  = 5;
    localparam int T   = 4;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_ren = 1'b0;
    logic [RW-1:0] rd = '0;
    logic [RW-1:0] rs1 = '0;
    logic [RW-1:0] rs2 = '0;
    logic          rs1u = 1'b0;
    logic          rs2u = 1'b0;
    logic          redir = 1'b0;
    logic          mreq = 1'b0;
    logic          ack = 1'b0;

    logic          dmem_req, hold_pc, hold_ifid, hold_idex, hold_exmem;
    logic          flush_ifid, bubble_idex, bubble_memwb, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(RW), .TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .idex_mem_ren_i(mem_ren), .idex_rd_addr_i(rd),
        .ifid_rs1_addr_i(rs1), .ifid_rs2_addr_i(rs2),
        .ifid_rs1_used_i(rs1u), .ifid_rs2_used_i(rs2u),
        .ex_redirect_i(redir), .exmem_mem_req_i(mreq), .dmem_ack_i(ack),
        .dmem_req_o(dmem_req), .hold_pc_o(hold_pc), .hold_ifid_o(hold_ifid),
        .hold_idex_o(hold_idex), .hold_exmem_o(hold_exmem),
        .flush_ifid_o(flush_ifid), .bubble_idex_o(bubble_idex),
        .bubble_memwb_o(bubble_memwb), .mem_err_o(mem_err),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Model: is an access outstanding, how many unanswered WAIT cycles so far, frozen?
    bit m_waiting, m_err;
    int m_unanswered, m_stall, m_flush;
    bit e_req, e_busy, e_hpc, e_hifid, e_hidex, e_hexmem, e_fl, e_bidex, e_bmw, e_redir;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_outputs();
        bit lu;
        if (rst) begin
            m_waiting = 0; m_err = 0; m_unanswered = 0; m_stall = 0; m_flush = 0;
        end
        e_req  = !rst && !m_err && (m_waiting || mreq);
        e_busy = e_req && !ack;
        lu = mem_ren && rd != 0 && ((rs1u && rs1 == rd) || (rs2u && rs2 == rd));
        {e_hpc, e_hifid, e_hidex, e_hexmem, e_fl, e_bidex, e_bmw, e_redir} = '0;
        if (rst) begin
            e_fl = 1; e_bidex = 1; e_bmw = 1;
        end else if (m_err || e_busy) begin
            e_hpc = 1; e_hifid = 1; e_hidex = 1; e_hexmem = 1; e_bmw = 1;
        end else if (redir) begin
            e_fl = 1; e_bidex = 1; e_redir = 1;
        end else if (lu) begin
            e_hpc = 1; e_hifid = 1; e_bidex = 1;
        end
    endtask

    // The single compare point, mid-cycle, after inputs have settled.
    task automatic eval();
        #2;
        model_outputs();
        chk("dmem_req", dmem_req, e_req);
        chk("hold_pc", hold_pc, e_hpc);
        chk("hold_ifid", hold_ifid, e_hifid);
        chk("hold_idex", hold_idex, e_hidex);
        chk("hold_exmem", hold_exmem, e_hexmem);
        chk("flush_ifid", flush_ifid, e_fl);
        chk("bubble_idex", bubble_idex, e_bidex);
        chk("bubble_memwb", bubble_memwb, e_bmw);
        chk("mem_err", mem_err, m_err);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
    endtask

    task automatic adv();
        @(posedge clk);
        if (!rst) begin
            if (e_hpc && m_stall < SAT) m_stall++;
            if (e_redir && m_flush < SAT) m_flush++;
            if (!m_err) begin
                if (m_waiting) begin
                    if (ack) m_waiting = 0;
                    else begin
                        m_unanswered++;
                        if (m_unanswered == T) begin m_err = 1; m_waiting = 0; end
                    end
                end else if (e_busy) begin
                    m_waiting = 1; m_unanswered = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle_in();
        mem_ren = 0; rd = 0; rs1 = 0; rs2 = 0; rs1u = 0; rs2u = 0;
        redir = 0; mreq = 0; ack = 0;
    endtask

    task automatic load_use_in(input logic [RW-1:0] r);
        mem_ren = 1; rd = r; rs2 = 5'd5; rs2u = 1; rs1 = 5'd7; rs1u = 1;
    endtask

    initial begin
        idle_in();
        rst = 1;
        #1;
        eval();
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_flush_ifid", flush_ifid, 1);
        chk("rst_bubble_memwb", bubble_memwb, 1);
        chk("rst_hold_pc", hold_pc, 0);
        adv();
        rst = 0;

        // Load-use on rs2
        load_use_in(5'd5);
        eval();
        chk("lu_hold_pc", hold_pc, 1);
        chk("lu_bubble_idex", bubble_idex, 1);
        chk("lu_flush_ifid", flush_ifid, 0);
        adv();
        idle_in();
        eval();
        chk("lu_stall_cnt", stall_cnt, 1);
        adv();

        // Destination x0 never interlocks
        load_use_in(5'd0); rs2 = 5'd0;
        eval();
        chk("x0_hold_pc", hold_pc, 0);
        adv();
        idle_in();

        // Ack three cycles after request
        mreq = 1;
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("wait_hold_exmem", hold_exmem, 1);
            chk("wait_dmem_req", dmem_req, 1);
            adv();
        end
        ack = 1;
        eval();
        chk("ack_hold_pc", hold_pc, 0);
        chk("ack_dmem_req", dmem_req, 1);
        adv();
        idle_in();
        eval();
        chk("ack_back_idle", dmem_req, 0);
        chk("ack_stall_cnt", stall_cnt, 4);
        adv();

        // Zero-wait access
        mreq = 1; ack = 1;
        eval();
        chk("zw_hold_pc", hold_pc, 0);
        adv();
        idle_in();
        eval();
        chk("zw_still_idle", dmem_req, 0);
        adv();

        // Redirect beats load-use
        load_use_in(5'd5); redir = 1;
        eval();
        chk("redir_flush", flush_ifid, 1);
        chk("redir_hold_pc", hold_pc, 0);
        adv();
        idle_in();
        eval();
        chk("redir_flush_cnt", flush_cnt, 1);
        adv();

        // Redirect during memory wait is deferred
        mreq = 1; redir = 1;
        eval();
        chk("defer_flush", flush_ifid, 0);
        chk("defer_hold_pc", hold_pc, 1);
        adv();
        ack = 1;
        eval();
        adv();
        idle_in();
        eval();
        adv();

        // Ack in the last allowed WAIT cycle avoids the error
        mreq = 1;
        for (int i = 0; i < T; i++) begin eval(); adv(); end
        ack = 1;
        eval();
        chk("late_ack_dmem_req", dmem_req, 1);
        adv();
        idle_in();
        eval();
        chk("late_ack_no_err", mem_err, 0);
        chk("late_ack_idle", dmem_req, 0);
        adv();

        // Async reset in the middle of WAIT
        mreq = 1;
        for (int i = 0; i < 2; i++) begin eval(); adv(); end
        rst = 1;
        eval();
        chk("midrst_dmem_req", dmem_req, 0);
        chk("midrst_hold_exmem", hold_exmem, 0);
        chk("midrst_stall_cnt", stall_cnt, 0);
        chk("midrst_flush_cnt", flush_cnt, 0);
        adv();
        rst = 0; mreq = 0;
        eval();
        chk("midrst_idle", dmem_req, 0);
        adv();

        // Timeout: IDLE cycle plus T unanswered WAIT cycles
        mreq = 1;
        for (int i = 0; i < T + 1; i++) begin eval(); adv(); end
        eval();
        chk("to_mem_err", mem_err, 1);
        chk("to_dmem_req", dmem_req, 0);
        chk("to_hold_pc", hold_pc, 1);
        adv();
        ack = 1; mreq = 0;
        eval();
        chk("to_sticky", mem_err, 1);
        adv();
        idle_in();
        rst = 1;
        eval();
        adv();
        rst = 0;

        // Stall counter saturation
        load_use_in(5'd5);
        for (int i = 0; i < 20; i++) begin eval(); adv(); end
        idle_in();
        eval();
        chk("sat_stall_cnt", stall_cnt, SAT);
        adv();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 99) < 2);
            mem_ren = 1'($urandom_range(0, 1));
            rd      = RW'($urandom_range(0, 3));
            rs1     = RW'($urandom_range(0, 3));
            rs2     = RW'($urandom_range(0, 3));
            rs1u    = 1'($urandom_range(0, 1));
            rs2u    = 1'($urandom_range(0, 1));
            redir   = ($urandom_range(0, 3) == 0);
            mreq    = ($urandom_range(0, 2) == 0);
            ack     = ($urandom_range(0, 2) == 0);
            eval();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
